fir_addr_gen_v2: RTL and testbench

FIR_ADDR_GEN_V2 -- requirements
Module: fir_addr_gen_v2

---
 rtl/fir_addr_gen_v2.sv | 230 +++++++++++++++++++++++
 tb/tb_fir_addr_gen_v2.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fir_addr_gen_v2.sv
// ============================================================================
// fir_addr_gen_v2
// ----------------------------------------------------------------------------
// Address and control sequencer for a single-MAC FIR filter that keeps its
// sample history in a circular data RAM and its coefficients in a tap RAM.
//
// A run starts with ap_start in IDLE.
// 1. The first L data RAM words are cleared.
// 2. For each input sample:
//    - write the sample at the head slot;
//    - sweep L tap/data pairs through the MAC, newest sample first;
//    - present the result until downstream accepts it;
//    - advance the head slot.
// 3. The run ends after the sample flagged ss_last has been processed.
//
// Ports
//   axis_clk   in   clock, all state updates on the rising edge
//   axis_rst   in   synchronous active-high reset
//   ap_start   in   start a run (honoured only in IDLE)
//   tap_len    in   number of taps for the run; 0 or too large selects pTAP_MAX
//   ss_valid   in   input sample present
//   ss_last    in   input sample is the final one of the run
//   ss_ready   out  block accepts an input sample this cycle
//   data_addr  out  data RAM byte address
//   data_we    out  data RAM write strobe
//   data_clr   out  write zero instead of the sample
//   tap_addr   out  tap RAM byte address
//   mac_en     out  MAC consumes the current tap/data pair
//   mac_clr    out  MAC loads the product instead of accumulating
//   res_valid  out  accumulator result ready
//   res_last   out  result belongs to the final sample
//   res_ready  in   downstream takes the result
//   busy       out  sequencer is not idle
//   done       out  one-cycle end-of-run pulse
//   state_o    out  current state code
//
// Every output is decoded from registered state only (state, k, head, L and
// the latched last flag), so no input reaches an output combinationally.
// ============================================================================
module fir_addr_gen_v2 #(
    parameter int pADDR_WIDTH = 12,
    parameter int pTAP_MAX    = 11,
    parameter int pLEN_WIDTH  = 6
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic [pLEN_WIDTH-1:0]  tap_len,
    input  logic                   ss_valid,
    input  logic                   ss_last,
    output logic                   ss_ready,
    output logic [pADDR_WIDTH-1:0] data_addr,
    output logic                   data_we,
    output logic                   data_clr,
    output logic [pADDR_WIDTH-1:0] tap_addr,
    output logic                   mac_en,
    output logic                   mac_clr,
    output logic                   res_valid,
    output logic                   res_last,
    input  logic                   res_ready,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             state_o
);

    // Counter width large enough to hold any index 0..pTAP_MAX.
    localparam int                CNT_W     = $clog2(pTAP_MAX + 1);
    localparam int unsigned       TAP_MAX_U = pTAP_MAX;
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LEN_DFLT  = CNT_W'(TAP_MAX_U);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLR     = 3'd1,
        S_WAIT_IN = 3'd2,
        S_WRITE   = 3'd3,
        S_MAC     = 3'd4,
        S_RESULT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // Zero and out-of-range lengths both fall back to the full filter.
    function automatic logic [CNT_W-1:0] f_len_sel(input logic [pLEN_WIDTH-1:0] len);
        if ((len == '0) || (32'(len) > TAP_MAX_U)) begin
            return LEN_DFLT;
        end
        return CNT_W'(len);
    endfunction

    // Word index to byte address (32-bit words).
    function automatic logic [pADDR_WIDTH-1:0] f_byte_addr(input logic [CNT_W-1:0] idx);
        return pADDR_WIDTH'(idx) << 2;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_head;
    logic [CNT_W-1:0] r_len;
    logic             r_last;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_k_nxt;
    logic [CNT_W-1:0] w_head_nxt;
    logic [CNT_W-1:0] w_len_nxt;
    logic             w_last_nxt;

    logic             w_k_last;
    logic [CNT_W-1:0] w_hist_idx;

    assign w_k_last = (r_k == (r_len - ONE));

    // Slot holding the sample that is k steps older than the newest one.
    // Both head and k are below L, so a single conditional add of L is
    // enough to bring the difference back into 0..L-1.
    always_comb begin
        w_hist_idx = r_head - r_k;
        if (r_head < r_k) begin
            w_hist_idx = r_head + r_len - r_k;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_head  <= '0;
            r_len   <= LEN_DFLT;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_head  <= w_head_nxt;
            r_len   <= w_len_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_head_nxt  = r_head;
        w_len_nxt   = r_len;
        w_last_nxt  = r_last;

        ss_ready    = 1'b0;
        data_addr   = '0;
        data_we     = 1'b0;
        data_clr    = 1'b0;
        tap_addr    = '0;
        mac_en      = 1'b0;
        mac_clr     = 1'b0;
        res_valid   = 1'b0;
        res_last    = 1'b0;
        done        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_len_nxt   = f_len_sel(tap_len);
                    w_head_nxt  = '0;
                    w_k_nxt     = '0;
                    w_state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                data_we   = 1'b1;
                data_clr  = 1'b1;
                data_addr = f_byte_addr(r_k);
                if (w_k_last) begin
                    w_k_nxt     = '0;
                    w_state_nxt = S_WAIT_IN;
                end else begin
                    w_k_nxt = r_k + ONE;
                end
            end

            S_WAIT_IN: begin
                ss_ready = 1'b1;
                if (ss_valid) begin
                    w_last_nxt  = ss_last;
                    w_state_nxt = S_WRITE;
                end
            end

            S_WRITE: begin
                data_we     = 1'b1;
                data_addr   = f_byte_addr(r_head);
                w_k_nxt     = '0;
                w_state_nxt = S_MAC;
            end

            S_MAC: begin
                mac_en    = 1'b1;
                mac_clr   = (r_k == '0);
                tap_addr  = f_byte_addr(r_k);
                data_addr = f_byte_addr(w_hist_idx);
                if (w_k_last) begin
                    w_k_nxt     = '0;
                    // Next sample goes one slot further round the ring.
                    w_head_nxt  = (r_head == (r_len - ONE)) ? '0 : (r_head + ONE);
                    w_state_nxt = S_RESULT;
                end else begin
                    w_k_nxt = r_k + ONE;
                end
            end

            S_RESULT: begin
                res_valid = 1'b1;
                res_last  = r_last;
                if (res_ready) begin
                    w_state_nxt = r_last ? S_DONE : S_WAIT_IN;
                end
            end

            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state != S_IDLE);
    assign state_o = r_state;

endmodule

// File: tb/tb_fir_addr_gen_v2.sv
module tb_fir_addr_gen_v2;

    localparam int ADDR_W  = 12;
    localparam int TAP_MAX = 11;
    localparam int LEN_W   = 6;

    logic              axis_clk;
    logic              axis_rst;
    logic              ap_start;
    logic [LEN_W-1:0]  tap_len;
    logic              ss_valid;
    logic              ss_last;
    logic              ss_ready;
    logic [ADDR_W-1:0] data_addr;
    logic              data_we;
    logic              data_clr;
    logic [ADDR_W-1:0] tap_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              res_valid;
    logic              res_last;
    logic              res_ready;
    logic              busy;
    logic              done;
    logic [2:0]        state_o;

    fir_addr_gen_v2 #(
        .pADDR_WIDTH(ADDR_W),
        .pTAP_MAX   (TAP_MAX),
        .pLEN_WIDTH (LEN_W)
    ) dut (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .ap_start (ap_start),
        .tap_len  (tap_len),
        .ss_valid (ss_valid),
        .ss_last  (ss_last),
        .ss_ready (ss_ready),
        .data_addr(data_addr),
        .data_we  (data_we),
        .data_clr (data_clr),
        .tap_addr (tap_addr),
        .mac_en   (mac_en),
        .mac_clr  (mac_clr),
        .res_valid(res_valid),
        .res_last (res_last),
        .res_ready(res_ready),
        .busy     (busy),
        .done     (done),
        .state_o  (state_o)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // One entry per clock cycle: inputs to drive and outputs expected.
    typedef struct {
        bit               rst;
        bit               ap;
        logic [LEN_W-1:0] tl;
        bit               sv;
        bit               sl;
        bit               rr;
        logic [35:0]      exp;
    } rec_t;

    rec_t plan[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [LEN_W-1:0] rl6();
        return LEN_W'($urandom);
    endfunction

    // Expected vector layout:
    // {state, busy, done, ss_ready, we, clr, mac_en, mac_clr, res_valid,
    //  res_last, data_addr, tap_addr}
    task automatic push(input bit rst, input bit ap, input logic [LEN_W-1:0] tl,
                        input bit sv, input bit sl, input bit rr,
                        input int st, input bit rdy, input bit we, input bit clr,
                        input bit men, input bit mclr, input bit rv, input bit rlst,
                        input int da, input int ta);
        rec_t r;
        r.rst = rst;
        r.ap  = ap;
        r.tl  = tl;
        r.sv  = sv;
        r.sl  = sl;
        r.rr  = rr;
        r.exp = {3'(st), (st != 0), (st == 6), rdy, we, clr, men, mclr, rv, rlst,
                 12'(da), 12'(ta)};
        plan.push_back(r);
    endtask

    // abort: 0 = full run, 1 = reset during first MAC at k=5,
    //        2 = reset during first RESULT after one stall cycle.
    task automatic plan_run(input int tl, input int nsamp, input int stall5_idx, input int abort);
        int L;
        int head;
        int gap;
        int stall;
        bit last;
        L = ((tl == 0) || (tl > TAP_MAX)) ? TAP_MAX : tl;
        gap = $urandom_range(1, 3);
        for (int i = 0; i < gap; i++)
            push(0, 0, rl6(), rb(), rb(), rb(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, LEN_W'(tl), rb(), rb(), rb(), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < L; k++)
            push(0, rb(), rl6(), rb(), rb(), rb(), 1, 0, 1, 1, 0, 0, 0, 0, k * 4, 0);
        head = 0;
        for (int s = 0; s < nsamp; s++) begin
            last = (s == nsamp - 1);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < gap; i++)
                push(0, rb(), rl6(), 0, rb(), rb(), 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            push(0, rb(), rl6(), 1, last, rb(), 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            push(0, rb(), rl6(), rb(), rb(), rb(), 3, 0, 1, 0, 0, 0, 0, 0, head * 4, 0);
            for (int k = 0; k < L; k++) begin
                int slot;
                slot = (((head - k) % L) + L) % L;
                if (abort == 1 && s == 0 && k == 5) begin
                    push(1, 1, rl6(), rb(), rb(), rb(), 4, 0, 0, 0, 1, 0, 0, 0, slot * 4, k * 4);
                    return;
                end
                push(0, rb(), rl6(), rb(), rb(), rb(), 4, 0, 0, 0, 1, (k == 0), 0, 0, slot * 4, k * 4);
            end
            head = (head + 1) % L;
            stall = (s == stall5_idx) ? 5 : $urandom_range(0, 3);
            if (abort == 2 && s == 0) begin
                push(0, rb(), rl6(), rb(), rb(), 0, 5, 0, 0, 0, 0, 0, 1, last, 0, 0);
                push(1, 1, rl6(), rb(), rb(), 1, 5, 0, 0, 0, 0, 0, 1, last, 0, 0);
                return;
            end
            for (int i = 0; i < stall; i++)
                push(0, rb(), rl6(), rb(), rb(), 0, 5, 0, 0, 0, 0, 0, 1, last, 0, 0);
            push(0, rb(), rl6(), rb(), rb(), 1, 5, 0, 0, 0, 0, 0, 1, last, 0, 0);
        end
        push(0, rb(), rl6(), rb(), rb(), rb(), 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        axis_rst  = 1'b1;
        ap_start  = 1'b1;
        tap_len   = '0;
        ss_valid  = 1'b0;
        ss_last   = 1'b0;
        res_ready = 1'b0;

        plan_run(11, 12, 1, 0);
        plan_run(0, 3, -1, 0);
        plan_run(1, 3, 0, 0);
        plan_run(11, 2, -1, 1);
        plan_run(11, 2, -1, 0);
        plan_run(20, 2, -1, 0);
        plan_run(4, 2, -1, 2);
        plan_run(4, 3, 2, 0);
        for (int r = 0; r < 6; r++)
            plan_run($urandom_range(0, 63), $urandom_range(1, 5), -1, 0);

        repeat (2) @(posedge axis_clk);
        for (int i = 0; i < plan.size(); i++) begin
            logic [35:0] got;
            #1;
            axis_rst  = plan[i].rst;
            ap_start  = plan[i].ap;
            tap_len   = plan[i].tl;
            ss_valid  = plan[i].sv;
            ss_last   = plan[i].sl;
            res_ready = plan[i].rr;
            got = {state_o, busy, done, ss_ready, data_we, data_clr, mac_en, mac_clr,
                   res_valid, res_last, data_addr, tap_addr};
            check($sformatf("cyc%0d_st%0d", i, plan[i].exp[35:33]), 64'(got), 64'(plan[i].exp));
            @(posedge axis_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
